// File: rtl/rv_dm_arbiter.sv
// Two-port debug-memory arbiter with a timeout on the shared memory port.
// Define URV_DM_ARB_RR_EN for round-robin; the default build is fixed priority.
module rv_dm_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  input  logic [3:0]  p0_sel_i,
  output logic        p0_ready_o,
  output logic [31:0] p0_rdata_o,
  output logic        p0_err_o,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  input  logic [3:0]  p1_sel_i,
  output logic        p1_ready_o,
  output logic [31:0] p1_rdata_o,
  output logic        p1_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_sel_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        owner;
  logic [15:0] cnt;
  logic        gnt;

`ifdef URV_DM_ARB_RR_EN
  logic rr_last;

  // On a tie the port not granted last time wins.
  always_comb begin
    gnt = ~p0_req_i;
    if (p0_req_i && p1_req_i) gnt = ~rr_last;
  end
`else
  always_comb begin
    gnt = ~p0_req_i;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      owner       <= 1'b0;
      cnt         <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_sel_o   <= '0;
      p0_ready_o  <= 1'b0;
      p1_ready_o  <= 1'b0;
      p0_err_o    <= 1'b0;
      p1_err_o    <= 1'b0;
      p0_rdata_o  <= '0;
      p1_rdata_o  <= '0;
`ifdef URV_DM_ARB_RR_EN
      rr_last     <= 1'b1;
`endif
    end else begin
      p0_ready_o <= 1'b0;
      p1_ready_o <= 1'b0;
      p0_err_o   <= 1'b0;
      p1_err_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (p0_req_i || p1_req_i) begin
            owner       <= gnt;
            mem_req_o   <= 1'b1;
            mem_we_o    <= gnt ? p1_we_i    : p0_we_i;
            mem_addr_o  <= gnt ? p1_addr_i  : p0_addr_i;
            mem_wdata_o <= gnt ? p1_wdata_i : p0_wdata_i;
            mem_sel_o   <= gnt ? p1_sel_i   : p0_sel_i;
            cnt         <= '0;
            state       <= BUSY;
`ifdef URV_DM_ARB_RR_EN
            rr_last     <= gnt;
`endif
          end
        end
        BUSY: begin
          // An ack in the limit cycle still completes without error.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= DONE;
            if (owner) begin
              p1_ready_o <= 1'b1;
              p1_rdata_o <= mem_rdata_i;
            end else begin
              p0_ready_o <= 1'b1;
              p0_rdata_o <= mem_rdata_i;
            end
          end else if (cnt == CNT_LAST) begin
            mem_req_o <= 1'b0;
            state     <= DONE;
            if (owner) begin
              p1_ready_o <= 1'b1;
              p1_err_o   <= 1'b1;
              p1_rdata_o <= '0;
            end else begin
              p0_ready_o <= 1'b1;
              p0_err_o   <= 1'b1;
              p0_rdata_o <= '0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_dm_arbiter.sv
// Randomised bench for rv_dm_arbiter against a transaction-level model.
// Built with TIMEOUT_CYCLES=4 so timeouts are cheap to reach.
module tb_rv_dm_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i;
  logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
  logic [3:0]  p0_sel_i, p1_sel_i;
  logic        p0_ready_o, p0_err_o, p1_ready_o, p1_err_o;
  logic [31:0] p0_rdata_o, p1_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_sel_o;

  always #5 clk = ~clk;

  rv_dm_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i),
    .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i),
    .p0_sel_i(p0_sel_i), .p0_ready_o(p0_ready_o),
    .p0_rdata_o(p0_rdata_o), .p0_err_o(p0_err_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i),
    .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i),
    .p1_sel_i(p1_sel_i), .p1_ready_o(p1_ready_o),
    .p1_rdata_o(p1_rdata_o), .p1_err_o(p1_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_sel_o(mem_sel_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit          pend [2];
  logic        we_m [2];
  logic [31:0] addr_m [2];
  logic [31:0] wd_m [2];
  logic [3:0]  sel_m [2];
  logic [31:0] rd_m [2];
  int          last_g;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    p0_req_i   = pend[0];
    p0_we_i    = we_m[0];
    p0_addr_i  = addr_m[0];
    p0_wdata_i = wd_m[0];
    p0_sel_i   = sel_m[0];
    p1_req_i   = pend[1];
    p1_we_i    = we_m[1];
    p1_addr_i  = addr_m[1];
    p1_wdata_i = wd_m[1];
    p1_sel_i   = sel_m[1];
  endtask

  task automatic new_req(input int p, input logic we,
                         input logic [31:0] a, input logic [31:0] w,
                         input logic [3:0] s);
    pend[p]   = 1'b1;
    we_m[p]   = we;
    addr_m[p] = a;
    wd_m[p]   = w;
    sel_m[p]  = s;
    drive();
  endtask

  task automatic rnd_req(input int p);
    logic [31:0] a;
    a = ((p == 0) ? 32'h1000_0000 : 32'h2000_0000) | $urandom_range(0, 16'hffff);
    new_req(p, 1'($urandom), a, $urandom, 4'($urandom));
  endtask

  // Called at a negedge with the DUT idle; ack_at is the BUSY cycle
  // (1-based) carrying the ack, beyond TO means the memory never answers.
  task automatic run_txn(input int ack_at, input logic [31:0] rdat);
    int   w;
    int   done_t;
    logic err;
    logic [31:0] one_hot;
    chk("idle_mem_req", mem_req_o, 0);
    if (pend[0] && pend[1]) begin
`ifdef URV_DM_ARB_RR_EN
      w = 1 - last_g;
`else
      w = 0;
`endif
    end else begin
      w = pend[0] ? 0 : 1;
    end
    last_g  = w;
    err     = ack_at > TO;
    done_t  = err ? TO : ack_at;
    one_hot = (w == 1) ? 32'd2 : 32'd1;
    drive();
    mem_ack_i   = 1'($urandom);
    mem_rdata_i = $urandom;
    @(negedge clk);
    for (int t = 1; t <= done_t; t++) begin
      chk("busy_mem_req", mem_req_o, 1);
      chk("busy_we", mem_we_o, we_m[w]);
      chk("busy_addr", mem_addr_o, addr_m[w]);
      chk("busy_wdata", mem_wdata_o, wd_m[w]);
      chk("busy_sel", mem_sel_o, sel_m[w]);
      chk("busy_ready", {p1_ready_o, p0_ready_o}, 0);
      mem_ack_i   = (t == ack_at);
      mem_rdata_i = (t == ack_at) ? rdat : $urandom;
      @(negedge clk);
    end
    rd_m[w] = err ? 32'h0 : rdat;
    chk("done_mem_req", mem_req_o, 0);
    chk("done_ready", {p1_ready_o, p0_ready_o}, one_hot);
    chk("done_err", {p1_err_o, p0_err_o}, err ? one_hot : 32'd0);
    chk("done_rdata", (w == 1) ? p1_rdata_o : p0_rdata_o, rd_m[w]);
    chk("done_other_rdata", (w == 1) ? p0_rdata_o : p1_rdata_o, rd_m[1-w]);
    mem_ack_i   = 1'($urandom);
    mem_rdata_i = $urandom;
    @(negedge clk);
    mem_ack_i = 1'b0;
    pend[w]   = 1'b0;
    drive();
    chk("after_ready", {p1_ready_o, p0_ready_o}, 0);
    chk("after_err", {p1_err_o, p0_err_o}, 0);
    chk("after_mem_req", mem_req_o, 0);
    chk("hold_rdata0", p0_rdata_o, rd_m[0]);
    chk("hold_rdata1", p1_rdata_o, rd_m[1]);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("gap_mem_req", mem_req_o, 0);
      chk("gap_ready", {p1_ready_o, p0_ready_o}, 0);
    end
  endtask

  task automatic drain();
    while (pend[0] || pend[1]) run_txn($urandom_range(1, TO + 2), $urandom);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; we_m[p] = 1'b0; addr_m[p] = '0;
      wd_m[p] = '0; sel_m[p] = '0; rd_m[p] = '0;
    end
    last_g      = 1;
    rst_n_i     = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n_i = 1'b1;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_sel", mem_sel_o, 0);
    chk("rst_ready", {p1_ready_o, p0_ready_o}, 0);
    chk("rst_err", {p1_err_o, p0_err_o}, 0);
    chk("rst_rdata0", p0_rdata_o, 0);
    chk("rst_rdata1", p1_rdata_o, 0);

    new_req(0, 1'b0, 32'h100, 32'h0, 4'hf);
    run_txn(2, 32'hDEADBEEF);
    new_req(1, 1'b1, 32'h203, 32'hA5, 4'b1000);
    run_txn(1, 32'h0BAD_F00D);
    new_req(0, 1'b0, 32'h40, 32'h0, 4'hf);
    run_txn(TO + 3, 32'h5555_5555);
    new_req(1, 1'b0, 32'h80, 32'h0, 4'h3);
    run_txn(TO, 32'h1234_5678);

    for (int i = 0; i < 4; i++) begin
      if (!pend[0]) rnd_req(0);
      if (!pend[1]) rnd_req(1);
      run_txn($urandom_range(1, TO), $urandom);
    end
    drain();

    new_req(0, 1'b1, 32'h300, 32'hCAFE, 4'h1);
    @(negedge clk);
    chk("pre_rst_mem_req", mem_req_o, 1);
    @(negedge clk);
    rst_n_i = 1'b0;
    pend[0] = 1'b0;
    drive();
    @(negedge clk);
    rst_n_i = 1'b1;
    rd_m[0] = '0;
    rd_m[1] = '0;
    last_g  = 1;
    chk("mid_rst_mem_req", mem_req_o, 0);
    chk("mid_rst_addr", mem_addr_o, 0);
    chk("mid_rst_rdata0", p0_rdata_o, 0);
    chk("mid_rst_rdata1", p1_rdata_o, 0);
    idle_cycles(3);
    new_req(1, 1'b0, 32'h2000_0010, 32'h0, 4'hf);
    run_txn(3, 32'h7777_0001);

    for (int i = 0; i < 150; i++) begin
      if (!pend[0] && !pend[1] && ($urandom_range(0, 3) == 0))
        idle_cycles($urandom_range(1, 3));
      for (int p = 0; p < 2; p++)
        if (!pend[p] && ($urandom_range(0, 1) == 1)) rnd_req(p);
      if (!pend[0] && !pend[1]) rnd_req($urandom_range(0, 1));
      run_txn($urandom_range(1, TO + 2), $urandom);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
